bcd_cascade_counter: RTL and testbench
======================================

# bcd_cascade_counter

Parametrised cascaded BCD counter: a chain of NUM_DIGITS decimal digits where every digit below the top counts modulo 10 and the top digit counts modulo TOP_MOD. It is the clocked, up/down, loadable successor to the single-digit decade counter in the time-keeping path. With the defaults it is a mod-60 seconds/minutes counter, and it exposes a same-cycle terminal-count output so instances can chain into hours or days.

## Interface
- NUM_DIGITS, default 2: number of BCD digits, from 1 to 8.
- TOP_MOD, default 6: modulus of the most-significant digit, from 2 to 10. Total modulus is TOP_MOD·10^(NUM_DIGITS-1).
- clk  in  1: rising-edge clock.
- rst  in  1: reset, synchronous, active-high.
- en  in  1: count request, sampled at each rising edge of clk.
- up  in  1: direction; 1 counts up, 0 counts down.
- load  in  1: parallel load request.
- load_val  in  4·NUM_DIGITS: BCD value to load; digit 0 occupies bits [3:0].
- count  out  4·NUM_DIGITS: registered BCD count; digit 0 occupies bits [3:0].
- tc  out  1: combinational terminal count; asserted when the next enabled edge wraps.
- wrap  out  1: registered one-cycle pulse after a wrap.
- load_err  out  1: registered one-cycle pulse after a load that contained an illegal digit.

## Operation
- Priority at each edge, highest first: rst, then load, then en. With none of them asserted, the count holds.
- rst: count becomes 0, wrap becomes 0, load_err becomes 0.
- load: every digit d of load_val is checked against its modulus (10, or TOP_MOD for the top digit).
  - A digit below its modulus is loaded as given.
  - A digit at or above its modulus is loaded as 0, and load_err pulses.
  - en is ignored in a load cycle and wrap stays 0.
- Count, up direction (en=1, up=1): digit i increments when every lower digit is at its maximum (9 for low digits, TOP_MOD-1 for the top digit). A digit at its maximum that is incremented goes to 0.
- Count, down direction (en=1, up=0): digit i decrements when every lower digit is 0. A digit at 0 that is decremented goes to its maximum.
- Terminal condition:
  - Up: all digits at maximum, i.e. the count equals the maximum value.
  - Down: all digits are 0.
- tc = en & terminal(up) & ~rst & ~load. This is a purely combinational path from en, up, load and count, so a downstream instance can use it as its en in the same cycle.
- wrap goes high for exactly one cycle following any edge at which an enabled count passed the terminal condition. It therefore coincides with count being 0 (up) or the maximum value (down).
- A direction change is legal on any cycle and takes effect at that edge.
- No digit ever holds a non-BCD value or a value at or above its own modulus.

## Timing
- count, wrap and load_err change only on the rising edge of clk. tc settles within the cycle.
- Latency:
  - en to count: 1 edge.
  - load to count: 1 edge.
  - Wrap edge to wrap high: same edge (wrap is registered alongside count).
- rst asserted in the middle of a count wins over load and en at that edge. All outputs except tc are 0 in the next cycle, and tc is 0 while rst is high.
- en held high counts on every edge; there is no rate limiting.
- Worst-case combinational path: the NUM_DIGITS-deep carry/borrow chain, plus the tc output.

## Structure
- Shared package bcd_pkg holds:
  - BCD_W = 4;
  - BCD_MAX = 4'd9;
  - a function that returns a digit's modulus given its index, NUM_DIGITS and TOP_MOD;
  - a function that checks whether a digit is legal.
- Sub-module bcd_digit, with parameter MOD. Its ports are clk, rst, en_in, up, load, load_d, q, at_term, load_bad.
  - It holds one digit register.
  - at_term is combinational: q==MOD-1 when up=1, q==0 when up=0.
- The top level generates NUM_DIGITS instances of bcd_digit. en_in of digit i is en & AND(at_term of digits 0..i-1).
- The top level owns the wrap and load_err registers and the tc logic.

## Test plan
- Defaults (NUM_DIGITS=2, TOP_MOD=6): reset, then en=1 and up=1 for 59 edges → count=0x59 and tc=1. The 60th edge gives count=0x00 and wrap=1 for one cycle.
- Count down from 0x00 with en=1 and up=0: tc=1 beforehand, then one edge gives count=0x59 and a wrap pulse. A further 10 edges give 0x49.
- load=1, load_val=0x37 and en=1 in the same cycle → count=0x37, no increment, load_err=0, wrap=0.
- load_val=0x7A → count=0x00 and load_err pulses for one cycle. load_val=0x5B → count=0x50 and load_err pulses.
- Toggle en with a random pattern over 200 cycles, with rst asserted at count 0x42 while en=1 → count=0x00 next cycle. The count must match a scoreboard modulo 60 at all times.
- NUM_DIGITS=3, TOP_MOD=10: load 0x999, one up edge → 0x000 with a wrap pulse. Chaining two instances through tc matches a single mod-3600 reference.

Source files
------------

// File: rtl/bcd_pkg.sv
// Shared constants and helpers for the cascaded BCD counter.
// Latency: n/a (compile-time constants and pure functions only).
// Backpressure: n/a.
package bcd_pkg;

  localparam int BCD_W = 4;
  localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;

  // The most-significant digit uses the reduced modulus.
  // Every other digit counts modulo 10.
  function automatic int digit_mod(input int idx, input int num_digits, input int top_mod);
    return (idx == num_digits - 1) ? top_mod : int'(BCD_MAX) + 1;
  endfunction

  // A digit is legal when it is strictly below its modulus.
  // Moduli never exceed 10, so this also rejects non-BCD codes.
  function automatic logic digit_legal(input logic [BCD_W-1:0] d, input int mod);
    return int'(d) < mod;
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD digit register that counts modulo MOD, with synchronous load and reset.
// Latency: one clock edge from en_in or load to q. at_term and load_bad are combinational.
// Backpressure: none. en_in advances the digit on every edge at which it is high.
// Ports:
//   clk, rst (sync, active-high); en_in = step request; up = direction
//   load, load_d = parallel load; q = digit value
//   at_term = digit sits at its terminal value for the current direction
//   load_bad = the load value is illegal for this digit
module bcd_digit
  import bcd_pkg::*;
#(
  parameter int MOD = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_in,
  input  logic             up,
  input  logic             load,
  input  logic [BCD_W-1:0] load_d,
  output logic [BCD_W-1:0] q,
  output logic             at_term,
  output logic             load_bad
);

  localparam logic [BCD_W-1:0] DIG_MAX = BCD_W'(MOD - 1);

  logic [BCD_W-1:0] r_q;
  logic             w_legal;

  assign w_legal  = digit_legal(load_d, MOD);
  assign load_bad = load & ~w_legal;
  assign at_term  = up ? (r_q == DIG_MAX) : (r_q == '0);
  assign q        = r_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_q <= '0;
    end else if (load) begin
      // Illegal digits collapse to 0 so the register never holds an out-of-range value.
      r_q <= w_legal ? load_d : '0;
    end else if (en_in) begin
      if (up) r_q <= (r_q == DIG_MAX) ? '0 : r_q + 1'b1;
      else    r_q <= (r_q == '0) ? DIG_MAX : r_q - 1'b1;
    end
  end

endmodule

// File: rtl/bcd_cascade_counter.sv
// Cascaded up/down loadable BCD counter. Low digits count mod 10 and the top digit counts mod TOP_MOD.
// Latency: one edge from en or load to count. wrap and load_err are registered alongside count.
// Backpressure: none. tc is combinational so a following instance can use it as en in the same cycle.
// Ports:
//   clk, rst (sync, active-high); en, up = count request and direction
//   load, load_val = parallel BCD load (digit 0 in [3:0])
//   count = BCD count; tc = the next enabled edge wraps
//   wrap = pulse after a wrap; load_err = pulse after an illegal load
module bcd_cascade_counter
  import bcd_pkg::*;
#(
  parameter int NUM_DIGITS = 2,
  parameter int TOP_MOD    = 6
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        en,
  input  logic                        up,
  input  logic                        load,
  input  logic [BCD_W*NUM_DIGITS-1:0] load_val,
  output logic [BCD_W*NUM_DIGITS-1:0] count,
  output logic                        tc,
  output logic                        wrap,
  output logic                        load_err
);

  // w_chain[i] is the enable for digit i. w_chain[NUM_DIGITS] means every digit is terminal.
  logic [NUM_DIGITS:0]   w_chain;
  logic [NUM_DIGITS-1:0] w_at_term;
  logic [NUM_DIGITS-1:0] w_load_bad;
  logic                  r_wrap;
  logic                  r_load_err;

  assign w_chain[0] = en;

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
    localparam int DMOD = digit_mod(g, NUM_DIGITS, TOP_MOD);

    assign w_chain[g+1] = w_chain[g] & w_at_term[g];

    bcd_digit #(
      .MOD(DMOD)
    ) u_digit (
      .clk      (clk),
      .rst      (rst),
      .en_in    (w_chain[g]),
      .up       (up),
      .load     (load),
      .load_d   (load_val[g*BCD_W +: BCD_W]),
      .q        (count[g*BCD_W +: BCD_W]),
      .at_term  (w_at_term[g]),
      .load_bad (w_load_bad[g])
    );
  end

  // Load and reset both suppress counting, so they also suppress terminal count.
  assign tc = w_chain[NUM_DIGITS] & ~rst & ~load;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wrap     <= 1'b0;
      r_load_err <= 1'b0;
    end else begin
      r_wrap     <= tc;
      r_load_err <= load & (|w_load_bad);
    end
  end

  assign wrap     = r_wrap;
  assign load_err = r_load_err;

endmodule

// File: tb/tb_bcd_cascade_counter.sv
module tb_bcd_cascade_counter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Main instance: defaults, mod 60.
  logic       rst, en, up, load;
  logic [7:0] load_val, count;
  logic       tc, wrap, load_err;

  // Three digits, all mod 10, for a total modulus of 1000.
  logic        en3, up3, load3;
  logic [11:0] lv3, cnt3;
  logic        tc3, wrap3, le3;

  // Two mod-60 instances chained through tc, for a total modulus of 3600.
  logic       ce, cu;
  logic [7:0] c0_cnt, c1_cnt;
  logic       c0_tc, c1_tc, c0_wrap, c1_wrap, c0_le, c1_le;

  bcd_cascade_counter #(.NUM_DIGITS(2), .TOP_MOD(6)) dut (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val),
    .count(count), .tc(tc), .wrap(wrap), .load_err(load_err));

  bcd_cascade_counter #(.NUM_DIGITS(3), .TOP_MOD(10)) dut3 (
    .clk(clk), .rst(rst), .en(en3), .up(up3), .load(load3), .load_val(lv3),
    .count(cnt3), .tc(tc3), .wrap(wrap3), .load_err(le3));

  bcd_cascade_counter #(.NUM_DIGITS(2), .TOP_MOD(6)) c0 (
    .clk(clk), .rst(rst), .en(ce), .up(cu), .load(1'b0), .load_val(8'h00),
    .count(c0_cnt), .tc(c0_tc), .wrap(c0_wrap), .load_err(c0_le));

  bcd_cascade_counter #(.NUM_DIGITS(2), .TOP_MOD(6)) c1 (
    .clk(clk), .rst(rst), .en(c0_tc), .up(cu), .load(1'b0), .load_val(8'h00),
    .count(c1_cnt), .tc(c1_tc), .wrap(c1_wrap), .load_err(c1_le));

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] to_bcd(input int v);
    logic [3:0] hi, lo;
    hi = 4'(v / 10);
    lo = 4'(v % 10);
    return {hi, lo};
  endfunction

  // The reference model for the mod-60 instance is an integer value plus two pulse flags.
  int m_v;
  bit m_w, m_le;

  // Drive inputs first, then call step. It checks tc before the edge,
  // applies the rules to the model at the edge, and checks the registered outputs after it.
  task automatic step(input string tag);
    logic exp_tc;
    int   hi, lo;
    exp_tc = en && !rst && !load && (up ? (m_v == 59) : (m_v == 0));
    #1;
    check({tag, ":tc"}, 32'(tc), 32'(exp_tc));
    @(posedge clk);
    if (rst) begin
      m_v = 0; m_w = 0; m_le = 0;
    end else if (load) begin
      lo   = int'(load_val[3:0]);
      hi   = int'(load_val[7:4]);
      m_le = (lo >= 10) || (hi >= 6);
      if (lo >= 10) lo = 0;
      if (hi >= 6)  hi = 0;
      m_v  = hi * 10 + lo;
      m_w  = 0;
    end else if (en) begin
      m_w  = up ? (m_v == 59) : (m_v == 0);
      m_v  = up ? (m_v + 1) % 60 : (m_v + 59) % 60;
      m_le = 0;
    end else begin
      m_w = 0; m_le = 0;
    end
    @(negedge clk);
    check({tag, ":count"}, 32'(count), 32'(to_bcd(m_v)));
    check({tag, ":wrap"}, 32'(wrap), 32'(m_w));
    check({tag, ":load_err"}, 32'(load_err), 32'(m_le));
  endtask

  int cv;

  initial begin
    rst = 1; en = 0; up = 1; load = 0; load_val = '0;
    en3 = 0; up3 = 1; load3 = 0; lv3 = '0;
    ce = 0; cu = 1;
    m_v = 0; m_w = 0; m_le = 0;
    @(negedge clk);
    step("reset");

    // Count up 59 times, then wrap on the 60th edge.
    rst = 0; en = 1; up = 1;
    repeat (59) step("up");
    check("at59", 32'(count), 32'h59);
    step("wrap60");
    en = 0;
    step("hold");

    // Count down through zero, then step down ten more times.
    en = 1; up = 0;
    step("down_wrap");
    repeat (10) step("down");
    check("at49", 32'(count), 32'h49);

    // Loads, including illegal digits.
    load = 1; en = 1; up = 1; load_val = 8'h37;
    step("load37");
    load_val = 8'h7A;
    step("load7A");
    load = 0; en = 0;
    step("after7A");
    load = 1; load_val = 8'h5B;
    step("load5B");
    load = 0;
    step("after5B");

    // Random traffic, with a forced reset while counting at 0x42.
    for (int i = 0; i < 200; i++) begin
      if (i == 100) begin
        load = 1; load_val = 8'h41; en = 0;
        step("pre42");
        load = 0; en = 1; up = 1;
        step("to42");
        rst = 1; en = 1;
        step("rst42");
        rst = 0;
      end
      en       = 1'($urandom_range(0, 1));
      up       = ($urandom_range(0, 3) != 0);
      load     = ($urandom_range(0, 15) == 0);
      load_val = 8'($urandom);
      step("rand");
    end
    en = 0; load = 0;

    // Three digits, mod 1000.
    load3 = 1; lv3 = 12'h999;
    @(posedge clk); @(negedge clk);
    check("d3:load999", 32'(cnt3), 32'h999);
    load3 = 0; en3 = 1; up3 = 1;
    #1 check("d3:tc_up", 32'(tc3), 32'd1);
    @(posedge clk); @(negedge clk);
    check("d3:wrap_cnt", 32'(cnt3), 32'h000);
    check("d3:wrap", 32'(wrap3), 32'd1);
    up3 = 0;
    #1 check("d3:tc_down", 32'(tc3), 32'd1);
    @(posedge clk); @(negedge clk);
    check("d3:down_cnt", 32'(cnt3), 32'h999);
    check("d3:down_wrap", 32'(wrap3), 32'd1);
    en3 = 0; load3 = 1; lv3 = 12'hA5C;
    @(posedge clk); @(negedge clk);
    check("d3:loadA5C", 32'(cnt3), 32'h050);
    check("d3:load_err", 32'(le3), 32'd1);
    check("d3:wrap_clear", 32'(wrap3), 32'd0);
    load3 = 0;

    // The two chained instances must follow a single mod-3600 reference.
    rst = 1;
    @(posedge clk); @(negedge clk);
    rst = 0; cv = 0;
    for (int i = 0; i < 300; i++) begin
      ce = ($urandom_range(0, 3) != 0);
      cu = ($urandom_range(0, 2) != 0);
      #1 check("chain:tc", 32'(c1_tc), 32'(ce && (cu ? (cv == 3599) : (cv == 0))));
      @(posedge clk);
      if (ce) cv = cu ? (cv + 1) % 3600 : (cv + 3599) % 3600;
      @(negedge clk);
      check("chain:count", 32'({c1_cnt, c0_cnt}), 32'({to_bcd(cv / 60), to_bcd(cv % 60)}));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
